mem_access_unit: RTL and testbench

Memory-stage access initiator of the P6 pipelined MIPS core; drives the data-memory port (address, write data, byte enables) toward the external data memory and captures returned load data. Converts M-stage load/store requests into byte-enable transactions and registers the result into the M/W boundary. Produces sign/zero-extended load data for write-back and maintains alignment-error status.

---
 rtl/mem_access_unit.sv | 156 +++++++++++++++
 tb/tb_mem_access_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage access initiator: drives byte-enable data-memory requests from M,
// registers loads into the M/W boundary and extends them for write-back.
module mem_access_unit #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m_req_valid,
    input  logic [3:0]       m_op,
    input  logic [31:0]      m_addr,
    input  logic [31:0]      m_store_data,
    input  logic [31:0]      m_pc,
    input  logic [4:0]       m_rd,
    output logic [31:0]      m_data_addr,
    output logic [31:0]      m_data_wdata,
    output logic [3:0]       m_data_byteen,
    output logic [31:0]      m_inst_addr,
    input  logic [31:0]      m_data_rdata,
    output logic             w_valid,
    output logic [4:0]       w_rd,
    output logic [31:0]      w_pc,
    output logic [31:0]      w_load_data,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count
);

    // m_req_valid qualifies the M fields for exactly one cycle and has no ready:
    // W never stalls. w_valid marks a completed aligned load for one cycle.
    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    logic             is_load;
    logic             is_store;
    logic             misaligned;
    logic             mis_evt;

    logic             w_valid_d,    w_valid_q;
    logic [4:0]       w_rd_d,       w_rd_q;
    logic [31:0]      w_pc_d,       w_pc_q;
    logic [31:0]      raw_d,        raw_q;
    logic [1:0]       off_d,        off_q;
    logic [3:0]       op_d,         op_q;
    logic             err_sticky_d, err_sticky_q;
    logic [ERR_W-1:0] err_count_d,  err_count_q;

    logic [15:0]      sel_half;
    logic [7:0]       sel_byte;

    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        case (m_op)
            OP_LW:         begin is_load  = 1'b1; misaligned = |m_addr[1:0]; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; misaligned = m_addr[0];    end
            OP_LB, OP_LBU: begin is_load  = 1'b1;                            end
            OP_SW:         begin is_store = 1'b1; misaligned = |m_addr[1:0]; end
            OP_SH:         begin is_store = 1'b1; misaligned = m_addr[0];    end
            OP_SB:         begin is_store = 1'b1;                            end
            default:       begin                                             end
        endcase
    end

    // Reset gates the enables combinationally so an in-flight store never commits.
    always_comb begin
        m_data_addr   = m_addr;
        m_inst_addr   = m_pc;
        m_data_wdata  = m_store_data;
        m_data_byteen = 4'b0000;
        case (m_op)
            OP_SH:   m_data_wdata = {2{m_store_data[15:0]}};
            OP_SB:   m_data_wdata = {4{m_store_data[7:0]}};
            default: m_data_wdata = m_store_data;
        endcase
        if (m_req_valid && !reset && is_store && !misaligned) begin
            case (m_op)
                OP_SW:   m_data_byteen = 4'b1111;
                OP_SH:   m_data_byteen = m_addr[1] ? 4'b1100 : 4'b0011;
                OP_SB:   m_data_byteen = 4'b0001 << m_addr[1:0];
                default: m_data_byteen = 4'b0000;
            endcase
        end
    end

    always_comb begin
        mis_evt      = m_req_valid && misaligned;
        w_valid_d    = m_req_valid && is_load && !misaligned;
        w_rd_d       = m_rd;
        w_pc_d       = m_pc;
        raw_d        = m_data_rdata;
        off_d        = m_addr[1:0];
        op_d         = m_op;
        err_sticky_d = err_sticky_q | mis_evt;
        err_count_d  = err_count_q;
        if (mis_evt && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_valid_q    <= 1'b0;
            w_rd_q       <= 5'd0;
            w_pc_q       <= 32'd0;
            raw_q        <= 32'd0;
            off_q        <= 2'd0;
            op_q         <= 4'd0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            w_valid_q    <= w_valid_d;
            w_rd_q       <= w_rd_d;
            w_pc_q       <= w_pc_d;
            raw_q        <= raw_d;
            off_q        <= off_d;
            op_q         <= op_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    // Little-endian lane selection: offset k picks bits [8k+7:8k].
    always_comb begin
        sel_half = off_q[1] ? raw_q[31:16] : raw_q[15:0];
        case (off_q)
            2'd0:    sel_byte = raw_q[7:0];
            2'd1:    sel_byte = raw_q[15:8];
            2'd2:    sel_byte = raw_q[23:16];
            default: sel_byte = raw_q[31:24];
        endcase
        w_load_data = 32'd0;
        if (w_valid_q) begin
            case (op_q)
                OP_LW:   w_load_data = raw_q;
                OP_LH:   w_load_data = {{16{sel_half[15]}}, sel_half};
                OP_LHU:  w_load_data = {16'd0, sel_half};
                OP_LB:   w_load_data = {{24{sel_byte[7]}}, sel_byte};
                OP_LBU:  w_load_data = {24'd0, sel_byte};
                default: w_load_data = 32'd0;
            endcase
        end
    end

    assign w_valid    = w_valid_q;
    assign w_rd       = w_rd_q;
    assign w_pc       = w_pc_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: external word memory, byte-level reference model,
// scoreboard queue of expected W-stage state popped by a negedge monitor.
module tb_mem_access_unit;

    localparam int ENT_W = 79;
    localparam logic [3:0] OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LB = 4'd4,
                           OP_LBU = 4'd5, OP_SW = 4'd6, OP_SH = 4'd7, OP_SB = 4'd8;

    logic        clk;
    logic        reset;
    logic        m_req_valid;
    logic [3:0]  m_op;
    logic [31:0] m_addr, m_store_data, m_pc;
    logic [4:0]  m_rd;
    logic [31:0] m_data_addr, m_data_wdata, m_inst_addr, m_data_rdata;
    logic [3:0]  m_data_byteen;
    logic        w_valid;
    logic [4:0]  w_rd;
    logic [31:0] w_pc, w_load_data;
    logic        err_sticky;
    logic [7:0]  err_count;

    int tests = 0;
    int fails = 0;

    logic [ENT_W-1:0] exp_q[$];

    // Reference state: byte-addressed memory image and error status.
    logic [7:0]  ref_mem[256];
    bit          ref_sticky;
    int          ref_cnt;
    logic [31:0] pc_ctr;

    // External data memory (environment, not the model).
    logic [31:0] mem[64];
    logic        init_we;
    logic [5:0]  init_idx;
    logic [31:0] init_data;

    mem_access_unit #(.ERR_W(8)) dut (
        .clk(clk), .reset(reset), .m_req_valid(m_req_valid), .m_op(m_op),
        .m_addr(m_addr), .m_store_data(m_store_data), .m_pc(m_pc), .m_rd(m_rd),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr),
        .m_data_rdata(m_data_rdata), .w_valid(w_valid), .w_rd(w_rd), .w_pc(w_pc),
        .w_load_data(w_load_data), .err_sticky(err_sticky), .err_count(err_count)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    assign m_data_rdata = mem[m_addr[7:2]];

    always @(posedge clk) begin
        if (init_we) begin
            mem[init_idx] <= init_data;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (m_data_byteen[k]) mem[m_addr[7:2]][8*k +: 8] <= m_data_wdata[8*k +: 8];
            end
        end
    end

    // ---------------- checks / model ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic model_req(input logic v, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] pc,
                             output logic [3:0] be, output logic [31:0] wd,
                             output logic [ENT_W-1:0] ent);
        int i, sz;
        bit ld, st, sgn, mis;
        logic [31:0] val;
        i = int'(a[7:0]);
        sz = 1; ld = 0; st = 0; sgn = 0;
        case (op)
            OP_LW:  begin ld = 1; sz = 4; end
            OP_LH:  begin ld = 1; sz = 2; sgn = 1; end
            OP_LHU: begin ld = 1; sz = 2; end
            OP_LB:  begin ld = 1; sz = 1; sgn = 1; end
            OP_LBU: begin ld = 1; sz = 1; end
            OP_SW:  begin st = 1; sz = 4; end
            OP_SH:  begin st = 1; sz = 2; end
            OP_SB:  begin st = 1; sz = 1; end
            default: ;
        endcase
        mis = (ld || st) && (i % sz != 0);
        if (v && mis) begin
            ref_sticky = 1;
            if (ref_cnt < 255) ref_cnt++;
        end
        val = 0; be = 0;
        wd = (sz == 4) ? sd : (sz == 2) ? {2{sd[15:0]}} : {4{sd[7:0]}};
        if (v && ld && !mis) begin
            for (int k = 0; k < sz; k++) val = val | (32'(ref_mem[i+k]) << (8*k));
            if (sgn && sz == 2 && val[15]) val[31:16] = 16'hFFFF;
            if (sgn && sz == 1 && val[7])  val[31:8]  = 24'hFFFFFF;
        end
        if (v && st && !mis) begin
            for (int k = 0; k < sz; k++) begin
                ref_mem[i+k] = sd[8*k +: 8];
                be[(i+k) % 4] = 1'b1;
            end
        end
        ent = {(v && ld && !mis), rd, pc, val, ref_sticky, 8'(ref_cnt)};
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1; returns at the next posedge+1 after queuing the W expectation.
    task automatic do_req(input logic v, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] sd, input logic [4:0] rd);
        logic [3:0] be;
        logic [31:0] wd;
        logic [ENT_W-1:0] ent;
        m_req_valid = v; m_op = op; m_addr = a; m_store_data = sd; m_rd = rd; m_pc = pc_ctr;
        #1;
        model_req(v, op, a, sd, rd, pc_ctr, be, wd, ent);
        chk("byteen", 32'(m_data_byteen), 32'(be));
        chk("data_addr", m_data_addr, a);
        chk("inst_addr", m_inst_addr, pc_ctr);
        if (be != 4'b0000) chk("wdata", m_data_wdata, wd);
        pc_ctr = pc_ctr + 32'd4;
        @(posedge clk);
        #1;
        exp_q.push_back(ent);
    endtask

    task automatic idle();
        m_req_valid = 1'b0; m_op = 4'd0; m_addr = 32'd0; m_store_data = 32'd0; m_rd = 5'd0;
    endtask

    task automatic chk_zero_state(input string tag);
        chk({tag, "_byteen"}, 32'(m_data_byteen), 32'd0);
        chk({tag, "_w_valid"}, 32'(w_valid), 32'd0);
        chk({tag, "_w_rd"}, 32'(w_rd), 32'd0);
        chk({tag, "_w_pc"}, w_pc, 32'd0);
        chk({tag, "_w_load_data"}, w_load_data, 32'd0);
        chk({tag, "_err_sticky"}, 32'(err_sticky), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [ENT_W-1:0] exp_e, act_e;
        if (!reset && exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            act_e = {w_valid, w_rd, w_pc, w_load_data, err_sticky, err_count};
            tests++;
            if (act_e !== exp_e) begin
                fails++;
                $display("FAIL w_stage {valid,rd,pc,data,sticky,cnt}: got %h expected %h", act_e, exp_e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] w, a;
        logic [3:0] op;
        reset = 1'b1; init_we = 1'b0; init_idx = 6'd0; init_data = 32'd0;
        pc_ctr = 32'h0040_0000; ref_sticky = 0; ref_cnt = 0;
        m_req_valid = 1'b1; m_op = OP_SW; m_addr = 32'h10; m_store_data = 32'hFFFF_FFFF;
        m_pc = 32'h1234; m_rd = 5'd7;
        #2;
        chk_zero_state("reset");
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            init_we = 1'b1; init_idx = 6'(i); init_data = w;
            for (int k = 0; k < 4; k++) ref_mem[i*4+k] = w[8*k +: 8];
            @(posedge clk);
            #1;
        end
        init_we = 1'b0;
        idle();
        reset = 1'b0;

        // Directed scenarios.
        do_req(1, OP_SW, 32'h10, 32'h12345678, 5'd1);
        do_req(1, OP_LW, 32'h10, 32'h0, 5'd2);
        do_req(1, OP_SB, 32'h13, 32'h000000AB, 5'd3);
        do_req(1, OP_LB, 32'h13, 32'h0, 5'd4);
        do_req(1, OP_LBU, 32'h13, 32'h0, 5'd5);
        do_req(1, OP_SW, 32'h20, 32'h0, 5'd6);
        do_req(1, OP_SH, 32'h22, 32'h00008001, 5'd7);
        do_req(1, OP_LH, 32'h22, 32'h0, 5'd8);
        do_req(1, OP_LHU, 32'h22, 32'h0, 5'd9);
        do_req(1, OP_LH, 32'h20, 32'h0, 5'd10);
        do_req(1, OP_LW, 32'h11, 32'h0, 5'd11);
        do_req(1, OP_SH, 32'h23, 32'hBEEF, 5'd12);
        chk("err_count_two", 32'(err_count), 32'd2);
        do_req(1, OP_LW, 32'h10, 32'h0, 5'd0);
        do_req(0, OP_SW, 32'h30, 32'hDEADBEEF, 5'd13);
        do_req(1, OP_LW, 32'h30, 32'h0, 5'd14);
        do_req(1, 4'd12, 32'h34, 32'h0, 5'd15);

        // Reset during a store while W holds a valid load.
        do_req(1, OP_LW, 32'h40, 32'h0, 5'd16);
        m_req_valid = 1'b1; m_op = OP_SW; m_addr = 32'h44; m_store_data = 32'hCAFEF00D;
        m_rd = 5'd17; m_pc = pc_ctr;
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_zero_state("mid_reset");
        @(posedge clk);
        #1;
        chk_zero_state("held_reset");
        ref_sticky = 0; ref_cnt = 0;
        idle();
        reset = 1'b0;
        do_req(1, OP_LW, 32'h44, 32'h0, 5'd18);

        // Random mix.
        for (int n = 0; n < 400; n++) begin
            do_req(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)), $urandom, $urandom,
                   5'($urandom_range(0, 31)));
        end

        // Misaligned flood drives the counter into saturation.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 4))
                0: op = OP_LW;
                1: op = OP_LH;
                2: op = OP_LHU;
                3: op = OP_SW;
                default: op = OP_SH;
            endcase
            a = $urandom | 32'd1;
            do_req(1, op, a, $urandom, 5'($urandom_range(0, 31)));
        end
        chk("err_count_saturated", 32'(err_count), 32'h000000FF);
        chk("err_sticky_set", 32'(err_sticky), 32'd1);

        idle();
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
